// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: builds the cause word, captures EPC, and sequences flush, handler entry and ERET return.
// Accept to handler redirect takes FLUSH_CYCLES+1 cycles, ERET to return redirect takes 1; requests are ignored while flushing.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        in_delay_slot,
  input  logic        exc_adel,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_ades,
  input  logic [5:0]  int_req,
  input  logic [5:0]  int_mask,
  input  logic        ie,
  input  logic        eret,
  output logic [31:0] reason,
  output logic        reason_we,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        exl,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] pc_redirect
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    REDIRECT = 3'd2,
    HANDLER  = 3'd3,
    RETURN   = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] reason_q, reason_d;
  logic [31:0] epc_q, epc_d;
  logic        exl_q, exl_d;
  logic        reason_we_q, reason_we_d;
  logic        epc_we_q, epc_we_d;

  logic        sync_any;
  logic        int_pend;
  logic [4:0]  exc_code;
  logic [31:0] new_reason;

  assign sync_any = exc_adel | exc_ri | exc_ov | exc_sys | exc_ades;
  assign int_pend = (|(int_req & int_mask)) && ie && !exl_q;

  always_comb begin
    exc_code = 5'd0;
    if (exc_adel)      exc_code = 5'd4;
    else if (exc_ri)   exc_code = 5'd10;
    else if (exc_ov)   exc_code = 5'd12;
    else if (exc_sys)  exc_code = 5'd8;
    else if (exc_ades) exc_code = 5'd5;
  end

  assign new_reason = {in_delay_slot, 15'd0, int_req, 3'd0, exc_code, 2'd0};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reason_d    = reason_q;
    epc_d       = epc_q;
    exl_d       = exl_q;
    reason_we_d = 1'b0;
    epc_we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_any || int_pend) begin
          state_d     = FLUSH;
          cnt_d       = 3'd0;
          reason_d    = new_reason;
          reason_we_d = 1'b1;
          epc_d       = in_delay_slot ? (pc_in - 32'd4) : pc_in;
          epc_we_d    = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = REDIRECT;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      REDIRECT: begin
        exl_d   = 1'b1;
        state_d = HANDLER;
      end
      HANDLER: begin
        // Nested exceptions keep the original EPC so ERET returns to the first fault.
        if (sync_any) begin
          state_d     = FLUSH;
          cnt_d       = 3'd0;
          reason_d    = new_reason;
          reason_we_d = 1'b1;
        end else if (eret) begin
          state_d = RETURN;
        end
      end
      RETURN: begin
        exl_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      reason_q    <= 32'd0;
      epc_q       <= 32'd0;
      exl_q       <= 1'b0;
      reason_we_q <= 1'b0;
      epc_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reason_q    <= reason_d;
      epc_q       <= epc_d;
      exl_q       <= exl_d;
      reason_we_q <= reason_we_d;
      epc_we_q    <= epc_we_d;
    end
  end

  assign reason         = reason_q;
  assign reason_we      = reason_we_q;
  assign epc            = epc_q;
  assign epc_we         = epc_we_q;
  assign exl            = exl_q;
  assign flush          = (state_q == FLUSH) || (state_q == REDIRECT) || (state_q == RETURN);
  assign redirect_valid = (state_q == REDIRECT) || (state_q == RETURN);
  assign pc_redirect    = (state_q == REDIRECT) ? HANDLER_ADDR :
                          (state_q == RETURN)   ? epc_q : 32'd0;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt controller that produces the 32-bit reason word for the CP0 cause register, along with its write strobe. It also captures EPC and sequences pipeline flush, handler entry and ERET return. It sits beside the CP0 registers and collects exception flags from the pipeline. It drives the flush and PC-redirect path into fetch.

Parameters:
HANDLER_ADDR, 32'h0000_0080, exception vector loaded into PC on entry
FLUSH_CYCLES, 2, cycles flush is held high before redirect (1..7)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
pc_in  in  32  PC of the instruction raising the exception
in_delay_slot  in  1  faulting instruction sits in a branch delay slot
exc_adel  in  1  load/fetch address error
exc_ri  in  1  reserved instruction
exc_ov  in  1  arithmetic overflow
exc_sys  in  1  syscall
exc_ades  in  1  store address error
int_req  in  6  hardware interrupt lines (level)
int_mask  in  6  per-line interrupt enable
ie  in  1  global interrupt enable
eret  in  1  ERET instruction in commit stage
reason  out  32  cause word to cause register
reason_we  out  1  one-cycle write strobe for reason
epc  out  32  captured exception PC
epc_we  out  1  one-cycle write strobe for epc
exl  out  1  exception level (1 while in handler)
flush  out  1  squash all pipeline stages
redirect_valid  out  1  one-cycle strobe: load pc_redirect into PC
pc_redirect  out  32  redirect target

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; all outputs 0, including reason, epc, exl and pc_redirect. Reset overrides any state, including mid-flush.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- Request in IDLE or HANDLER = any sync flag. In IDLE only, a pending enabled interrupt also counts: |(int_req & int_mask) && ie && !exl.
- Priority (highest first), with ExcCode: AdEL=4, RI=10, Ov=12, Sys=8, AdES=5, Int=0. Simultaneous flags: only the highest is recorded.
- reason format: [31]=BD (in_delay_slot), [15:10]=int_req sampled at the accept edge, [6:2]=ExcCode, all other bits 0.
- Accept edge: the request is sampled at the edge, and state goes to FLUSH.
  - reason is registered, and reason_we=1 for the first FLUSH cycle only.
  - In IDLE: epc = in_delay_slot ? pc_in-4 : pc_in (mod 2^32), and epc_we=1 in the same cycle as reason_we.
  - In HANDLER (nested, exl=1): epc holds its value, epc_we stays 0, and reason is still written.
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, then REDIRECT. New requests and eret are ignored during FLUSH.
- REDIRECT: lasts one cycle. redirect_valid=1, pc_redirect=HANDLER_ADDR, flush=1, exl set to 1 at the end of this cycle. Next state is HANDLER.
- HANDLER: flush=0. Interrupts are ignored. eret with no sync flag goes to RETURN. A sync flag with eret at the same edge gives the exception priority; eret is dropped.
- RETURN: lasts one cycle. flush=1, redirect_valid=1, pc_redirect=epc, exl cleared at the end of this cycle. Next state is IDLE.
- eret in IDLE: ignored, no outputs change.
- Latency: from the accept edge to redirect_valid is FLUSH_CYCLES+1 cycles. From the eret edge to redirect_valid is 1 cycle.
- reason and epc hold their value between writes.

Test Plan:
- Reset mid-FLUSH: assert exc_ov, then reset on the next edge -> next cycle state=IDLE; flush, reason_we and exl are 0; reason=0.
- exc_ov at pc_in=0x0040_0010, BD=0 -> reason=0x0000_0030 with reason_we and epc_we pulsed once; epc=0x0040_0010; flush high 2 cycles; redirect_valid with pc_redirect=0x80 in cycle 3 after accept; exl=1 afterwards.
- exc_ri+exc_sys+exc_ades together, in_delay_slot=1, pc_in=0x0000_1004 -> reason=0x8000_0028 (RI); epc=0x0000_1000.
- int_req=6'b000100, int_mask=6'b000100, ie=1, exl=0 -> reason=0x0000_1000; then the same interrupt held while in HANDLER -> no re-entry.
- eret in HANDLER with epc=0x0040_0010 -> next cycle flush=1, redirect_valid=1, pc_redirect=0x0040_0010; exl=0 after; eret in IDLE -> no activity.
- Nested exc_sys in HANDLER at pc_in=0x84 -> reason=0x0000_0020 written; epc_we=0 and epc unchanged; redirect to 0x80.
